// File: rtl/axi_sram_rd_slave.sv
// rtl/axi_sram_rd_slave.sv - AXI4 read-channel responder in front of a 1-cycle synchronous SRAM
//
// Accepts one AR burst at a time (FIXED/INCR/WRAP) and returns it beat by beat
// on R, issuing one SRAM read per beat and honouring rready backpressure.
// Ports:
//   clock, reset           clock, asynchronous active-high reset
//   arvalid/arready/ar*    read address channel
//   rvalid/rready/r*       read data channel
//   sram_ren, sram_addr    word-addressed SRAM read port
//   sram_rdata             SRAM data, valid the cycle after sram_ren

module axi_sram_rd_slave #(
   parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
   parameter int          ADDR_W    = 16,
   parameter int          LATENCY   = 0,
   parameter int          ID_W      = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              arvalid,
   output logic              arready,
   input  logic [31:0]       araddr,
   input  logic [ID_W-1:0]   arid,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   output logic              rvalid,
   input  logic              rready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic [ID_W-1:0]   rid,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [31:0]       sram_rdata
);

   typedef enum logic [2:0] {IDLE, WAIT, READ, DATA, RESP} state_t;

   // WAIT is left when the counter reaches zero, so it is preloaded with LATENCY-1.
   localparam logic [7:0] WAIT_INIT = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

   state_t            state, state_next;
   logic [31:0]       cur_addr;
   logic [ID_W-1:0]   id_q;
   logic [7:0]        len_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   logic [7:0]        beat;
   logic [7:0]        wait_cnt;

   logic [31:0]       offset;
   logic              dec_err, slv_err, beat_err;
   logic [1:0]        beat_resp;
   logic [31:0]       size_b, wrap_len, wrap_lo, next_addr;

   // Error status is judged per beat from the current beat address.
   assign offset    = cur_addr - ADDR_BASE;
   assign dec_err   = (offset >> (ADDR_W + 2)) != 32'd0;
   assign slv_err   = (size_q > 3'd2) || (burst_q == 2'b11) ||
                      ((burst_q == 2'b10) &&
                       !((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15)));
   assign beat_err  = slv_err || dec_err;
   assign beat_resp = slv_err ? 2'b10 : (dec_err ? 2'b11 : 2'b00);
   assign sram_addr = offset[ADDR_W+1:2];

   // Legal WRAP lengths are powers of two, so the modulo reduces to a mask;
   // illegal WRAP bursts are SLVERR on every beat and their addresses are unused.
   always_comb begin
      size_b    = 32'd1 << size_q;
      wrap_len  = (32'(len_q) + 32'd1) << size_q;
      wrap_lo   = cur_addr & ~(wrap_len - 32'd1);
      next_addr = cur_addr;
      case (burst_q)
         2'b00:   next_addr = cur_addr;
         2'b10:   next_addr = wrap_lo + ((cur_addr + size_b - wrap_lo) & (wrap_len - 32'd1));
         default: next_addr = cur_addr + size_b;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      arready    = 1'b0;
      sram_ren   = 1'b0;
      case (state)
         IDLE: begin
            arready = 1'b1;
            if (arvalid) state_next = (LATENCY > 0) ? WAIT : READ;
         end
         WAIT: if (wait_cnt == 8'd0) state_next = READ;
         READ: begin
            sram_ren   = !beat_err;
            state_next = DATA;
         end
         DATA: state_next = RESP;
         RESP: if (rready) state_next = rlast ? IDLE : READ;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_addr <= '0;
         id_q     <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat     <= '0;
         wait_cnt <= '0;
         rvalid   <= 1'b0;
         rlast    <= 1'b0;
         rresp    <= 2'b00;
         rdata    <= '0;
         rid      <= '0;
      end else begin
         case (state)
            IDLE: if (arvalid) begin
               cur_addr <= araddr;
               id_q     <= arid;
               len_q    <= arlen;
               size_q   <= arsize;
               burst_q  <= arburst;
               beat     <= 8'd0;
               wait_cnt <= WAIT_INIT;
            end
            WAIT: if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
            DATA: begin
               rdata  <= beat_err ? 32'd0 : sram_rdata;
               rvalid <= 1'b1;
               rlast  <= (beat == len_q);
               rresp  <= beat_resp;
               rid    <= id_q;
            end
            RESP: if (rready) begin
               rvalid <= 1'b0;
               rlast  <= 1'b0;
               if (!rlast) begin
                  beat     <= beat + 8'd1;
                  cur_addr <= next_addr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// tb/tb_axi_sram_rd_slave.sv - self-checking bench for axi_sram_rd_slave

module tb_axi_sram_rd_slave;

   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam logic [31:0] REGION = 32'h0004_0000;

   logic        clock, reset;
   logic        arvalid, arready, rvalid, rready, rlast, sram_ren;
   logic [31:0] araddr, rdata, sram_rdata;
   logic [3:0]  arid, rid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;
   logic [15:0] sram_addr;

   logic        arvalid3, arready3, rvalid3, rready3, rlast3, sram_ren3;
   logic [31:0] araddr3, rdata3, sram_rdata3;
   logic [3:0]  arid3, rid3;
   logic [7:0]  arlen3;
   logic [2:0]  arsize3;
   logic [1:0]  arburst3, rresp3;
   logic [15:0] sram_addr3;

   int checks = 0;
   int errors = 0;

   axi_sram_rd_slave dut (
      .clock(clock), .reset(reset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid),
      .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata)
   );

   axi_sram_rd_slave #(.LATENCY(3)) dut_l3 (
      .clock(clock), .reset(reset),
      .arvalid(arvalid3), .arready(arready3), .araddr(araddr3), .arid(arid3),
      .arlen(arlen3), .arsize(arsize3), .arburst(arburst3),
      .rvalid(rvalid3), .rready(rready3), .rdata(rdata3), .rresp(rresp3),
      .rlast(rlast3), .rid(rid3),
      .sram_ren(sram_ren3), .sram_addr(sram_addr3), .sram_rdata(sram_rdata3)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic [31:0] mem_f(input logic [15:0] w);
      return {w ^ 16'hA5C3, ~w};
   endfunction

   always @(posedge clock) if (sram_ren)  sram_rdata  <= mem_f(sram_addr);
   always @(posedge clock) if (sram_ren3) sram_rdata3 <= mem_f(sram_addr3);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected beat list of a burst, straight from the address/response rules.
   logic [1:0]  m_resp[$];
   logic [31:0] m_data[$];
   logic [15:0] m_wadr[$];

   task automatic build_model(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] a, sz, wl, lo, off;
      logic [1:0]  r;
      bit          bad;
      m_resp.delete(); m_data.delete(); m_wadr.delete();
      sz  = 32'd1 << size;
      wl  = (32'(len) + 32'd1) * sz;
      bad = (size > 3'd2) || (burst == 2'b11) ||
            ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         off = a - BASE;
         r   = bad ? 2'b10 : ((off < REGION) ? 2'b00 : 2'b11);
         m_resp.push_back(r);
         m_data.push_back((r == 2'b00) ? mem_f(off[17:2]) : 32'd0);
         if (r == 2'b00) m_wadr.push_back(off[17:2]);
         if (burst == 2'b01) a = a + sz;
         else if (burst == 2'b10) begin
            lo = a - (a % wl);
            a  = lo + ((a + sz - lo) % wl);
         end
      end
   endtask

   // rmode: 0 rready held high, 1 toggled each cycle, 2 random.
   task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int rmode,
                            output int nbeats, output logic [1:0] r0, output logic [1:0] rl,
                            output int nren, output logic [15:0] wa0);
      int          cyc, last_hs, budget;
      bit          done, hold, seen;
      logic [31:0] h_data;
      logic [6:0]  h_ctl;
      build_model(addr, len, size, burst);
      nbeats = 0; nren = 0; r0 = 2'b00; rl = 2'b00; wa0 = 16'h0;
      done = 0; hold = 0; seen = 0; last_hs = 0; h_data = 0; h_ctl = 0;
      budget = (int'(len) + 1) * 40 + 20;
      @(negedge clock);
      araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1; rready = 1'b0;
      chk("arready_idle", 32'(arready), 32'd1);
      @(negedge clock);
      arvalid = 1'b0;
      cyc = 1;
      while (!done && cyc < budget) begin
         case (rmode)
            0:       rready = 1'b1;
            1:       rready = cyc[0];
            default: rready = 1'($urandom_range(0, 1));
         endcase
         if (sram_ren) begin
            nren++;
            if (nren == 1) wa0 = sram_addr;
            if (m_wadr.size() == 0) chk("sram_ren_unexpected", 32'(sram_ren), 32'd0);
            else chk("sram_addr", 32'(sram_addr), 32'(m_wadr.pop_front()));
         end
         if (rvalid) begin
            // cyc counts negedges after the handshake edge; rvalid seen at cyc 3 rose 2 edges later.
            if (!seen) begin
               seen = 1;
               chk("first_rvalid_latency", 32'(cyc - 1), 32'd2);
            end
            if (hold) begin
               chk("hold_rdata", rdata, h_data);
               chk("hold_resp_last_id", 32'({rresp, rlast, rid}), 32'(h_ctl));
            end
            if (rready) begin
               if (nbeats >= m_resp.size()) chk("extra_beat", 32'(nbeats), 32'(m_resp.size()));
               else begin
                  chk("rdata", rdata, m_data[nbeats]);
                  chk("rresp", 32'(rresp), 32'(m_resp[nbeats]));
                  chk("rlast", 32'(rlast), 32'(nbeats == int'(len)));
                  chk("rid", 32'(rid), 32'(id));
               end
               if (rmode == 0 && nbeats > 0) chk("beat_spacing", 32'(cyc - last_hs), 32'd3);
               if (nbeats == 0) r0 = rresp;
               rl = rresp;
               last_hs = cyc;
               nbeats++;
               hold = 0;
               if (rlast) done = 1;
            end else begin
               hold   = 1;
               h_data = rdata;
               h_ctl  = {rresp, rlast, rid};
            end
         end else if (hold) begin
            chk("rvalid_dropped", 32'(rvalid), 32'd1);
            hold = 0;
         end
         @(negedge clock);
         cyc++;
      end
      chk("burst_done", 32'(done), 32'd1);
      chk("arready_after_last", 32'(arready), 32'd1);
      chk("rvalid_after_last", 32'(rvalid), 32'd0);
      chk("sram_reads_left", 32'(m_wadr.size()), 32'd0);
      rready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          rmode;
      int          exp_beats;
      logic [1:0]  exp_r0;
      logic [1:0]  exp_rl;
      int          exp_ren;
      logic [15:0] exp_wa0;
   } vec_t;

   vec_t vt[8];

   initial begin
      int          nb, nr, n, t, cyc;
      logic [1:0]  r0, rl;
      logic [15:0] wa;
      logic [31:0] ra;
      logic [7:0]  l;
      logic [2:0]  s;
      logic [1:0]  b;

      vt[0] = '{32'h8000_0024, 4'h3, 8'd15, 3'd2, 2'b10, 0, 16, 2'b00, 2'b00, 16, 16'h0009};
      vt[1] = '{32'h8000_0100, 4'h5, 8'd3,  3'd2, 2'b01, 1, 4,  2'b00, 2'b00, 4,  16'h0040};
      vt[2] = '{32'h8003_FFF8, 4'h6, 8'd3,  3'd2, 2'b01, 0, 4,  2'b00, 2'b11, 2,  16'hFFFE};
      vt[3] = '{32'h8000_0040, 4'h7, 8'd2,  3'd2, 2'b10, 0, 3,  2'b10, 2'b10, 0,  16'h0000};
      vt[4] = '{32'h8000_0040, 4'h8, 8'd0,  3'd3, 2'b01, 0, 1,  2'b10, 2'b10, 0,  16'h0000};
      vt[5] = '{32'h8000_0010, 4'h9, 8'd2,  3'd2, 2'b00, 2, 3,  2'b00, 2'b00, 3,  16'h0004};
      vt[6] = '{32'h8000_0000, 4'h1, 8'd1,  3'd2, 2'b11, 0, 2,  2'b10, 2'b10, 0,  16'h0000};
      vt[7] = '{32'h7FFF_FFF0, 4'h2, 8'd1,  3'd2, 2'b01, 2, 2,  2'b11, 2'b11, 0,  16'h0000};

      arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
      arvalid3 = 0; araddr3 = 0; arid3 = 0; arlen3 = 0; arsize3 = 0; arburst3 = 0; rready3 = 0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("reset_rvalid", 32'(rvalid), 32'd0);
      chk("reset_rlast", 32'(rlast), 32'd0);
      chk("reset_rresp", 32'(rresp), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_rid", 32'(rid), 32'd0);
      chk("reset_sram_ren", 32'(sram_ren), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("arready_after_reset", 32'(arready), 32'd1);
      chk("arready3_after_reset", 32'(arready3), 32'd1);

      for (int i = 0; i < 8; i++) begin
         run_burst(vt[i].addr, vt[i].id, vt[i].len, vt[i].size, vt[i].burst, vt[i].rmode,
                   nb, r0, rl, nr, wa);
         chk($sformatf("vec%0d_beats", i), 32'(nb), 32'(vt[i].exp_beats));
         chk($sformatf("vec%0d_first_resp", i), 32'(r0), 32'(vt[i].exp_r0));
         chk($sformatf("vec%0d_last_resp", i), 32'(rl), 32'(vt[i].exp_rl));
         chk($sformatf("vec%0d_sram_reads", i), 32'(nr), 32'(vt[i].exp_ren));
         if (vt[i].exp_ren > 0) chk($sformatf("vec%0d_first_word", i), 32'(wa), 32'(vt[i].exp_wa0));
      end

      for (int k = 0; k < 30; k++) begin
         b = 2'($urandom_range(0, 2));
         s = 3'($urandom_range(0, 2));
         if (b == 2'b10) l = 8'((1 << $urandom_range(1, 4)) - 1);
         else            l = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) ra = BASE + REGION - 32'(4 * $urandom_range(1, 8));
         else ra = BASE + (32'($urandom_range(0, 32'h3FFFF)) & ~((32'd1 << s) - 32'd1));
         run_burst(ra, 4'($urandom), l, s, b, int'($urandom_range(0, 2)), nb, r0, rl, nr, wa);
         chk("rand_beats", 32'(nb), 32'(l) + 32'd1);
      end

      // LATENCY=3 instance: single FIXED beat.
      @(negedge clock);
      araddr3 = 32'h8000_0008; arid3 = 4'hA; arlen3 = 8'd0; arsize3 = 3'd2; arburst3 = 2'b00;
      arvalid3 = 1'b1;
      chk("l3_arready", 32'(arready3), 32'd1);
      @(negedge clock);
      arvalid3 = 1'b0;
      cyc = 1;
      while (!rvalid3 && cyc < 30) begin
         @(negedge clock);
         cyc++;
      end
      chk("l3_first_rvalid_latency", 32'(cyc - 1), 32'd5);
      chk("l3_rlast", 32'(rlast3), 32'd1);
      chk("l3_rid", 32'(rid3), 32'hA);
      chk("l3_rresp", 32'(rresp3), 32'd0);
      chk("l3_rdata", rdata3, mem_f(16'h0002));
      rready3 = 1'b1;
      @(negedge clock);
      rready3 = 1'b0;
      chk("l3_rvalid_after", 32'(rvalid3), 32'd0);
      chk("l3_arready_after", 32'(arready3), 32'd1);

      // Asynchronous reset while beat 2 of a 4-beat INCR burst is on R.
      @(negedge clock);
      araddr = BASE + 32'h200; arid = 4'h4; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1; rready = 1'b1;
      @(negedge clock);
      arvalid = 1'b0;
      n = 0; t = 0;
      while (n < 2 && t < 40) begin
         if (rvalid) n++;
         if (n < 2) begin
            @(negedge clock);
            t++;
         end
      end
      chk("mid_burst_beat2_seen", 32'(n), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_rvalid", 32'(rvalid), 32'd0);
      chk("async_reset_rlast", 32'(rlast), 32'd0);
      chk("async_reset_rdata", rdata, 32'd0);
      @(negedge clock);
      reset = 1'b0; rready = 1'b0;
      @(negedge clock);
      chk("arready_after_async_reset", 32'(arready), 32'd1);
      run_burst(BASE + 32'h300, 4'hC, 8'd3, 3'd2, 2'b01, 0, nb, r0, rl, nr, wa);
      chk("post_reset_beats", 32'(nb), 32'd4);
      chk("post_reset_first_word", 32'(wa), 32'h00C0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
